muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative 32-bit multiply/divide unit that owns the HI/LO register pair for the single-cycle datapath. It sits beside the ALU and consumes the two register-file read operands (rs, rt). It executes mult/multu/div/divu over multiple cycles and supplies HI/LO to the write-back result mux for mfhi/mflo. While it runs, `busy` is the stall request to the control unit and program counter.

## Interface
- No parameters; operand width fixed at 32, HI/LO each 32.
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- start  in  1  request to begin operation `op` on `a`/`b`; sampled only when idle
- op  in  2  00 multu, 01 mult, 10 divu, 11 div
- a  in  32  rs operand (multiplicand / dividend)
- b  in  32  rt operand (multiplier / divisor)
- mthi  in  1  write `a` into HI (idle only)
- mtlo  in  1  write `a` into LO (idle only)
- busy  out  1  operation in progress; request stall
- done  out  1  one-cycle pulse: HI/LO just updated by an operation
- hi  out  32  HI register (mult: product[63:32]; div: remainder)
- lo  out  32  LO register (mult: product[31:0]; div: quotient)

## Operation
- States: IDLE, RUN, FIX.
- IDLE + start: latch op. Latch |a| and |b| (magnitude only for signed ops 01/11, raw for 00/10). Latch sign flags sa=a[31], sb=b[31] (signed ops; else 0). Latch divide-by-zero flag (div ops with b==0). Set count=31 and go to RUN.
- RUN, multiply: radix-2 shift-add, one multiplier bit per cycle into a 64-bit accumulator.
- RUN, divide: restoring division, one quotient bit per cycle; 33-bit partial remainder.
- RUN runs 32 cycles. On count==0, go to FIX. count decrements mod 32.
- FIX, multiply: if sa^sb, apply 64-bit two's-complement negation. Write {hi,lo}.
- FIX, divide: negate quotient if sa^sb; negate remainder if sa. Write lo=quotient, hi=remainder.
- FIX, divide-by-zero: hi=a as latched (raw), lo=0xFFFFFFFF. Same latency as a normal divide.
- FIX → IDLE. All arithmetic is modulo 2^32 / 2^64; no overflow flag. Example: div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- mthi/mtlo, IDLE and no start: the register is loaded from `a` on the next edge. Both asserted writes both.
- Simultaneous start and mthi/mtlo in IDLE: start wins; moves are ignored.
- start, mthi, and mtlo are all ignored while not IDLE. Operands a/b are don't-care after the start edge.

## Timing
- Reset (any state, including mid-RUN): abort the operation. State=IDLE, hi=0, lo=0, busy=0, done=0, count=0.
- Start accepted at edge E0. busy=1 from after E0 through the cycle before E33.
- RUN occupies edges E1..E32. FIX occupies edge E33, which writes hi/lo.
- After E33: busy=0, done=1 for exactly one cycle; hi/lo hold the new values.
- Latency from accepted start to valid HI/LO: 33 cycles.
- A new start is accepted in the same cycle done=1 (state is IDLE).
- hi/lo are stable during RUN; they hold their previous values until FIX.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- multu a=0xFFFFFFFF, b=0xFFFFFFFF → after E33: hi=0xFFFFFFFE, lo=0x00000001. done high exactly one cycle; busy high exactly 33 cycles.
- mult a=0xFFFFFFFD (-3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- mult a=0x80000000, b=0x80000000 → hi=0x40000000, lo=0.
- div a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- divu a=100, b=0 → hi=100, lo=0xFFFFFFFF, same 33-cycle latency.
- divu 100/7 started, then a second start (multu 2*3) at E10 → second start ignored; result hi=2, lo=14.
- reset asserted at E15 of a mult → next cycle hi=lo=0, busy=0, no done pulse.
- Idle mthi a=0x12345678, then mtlo a=0xCAFEBABE → hi=0x12345678, lo=0xCAFEBABE.
- mthi asserted together with start → ignored; only the operation result is written.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit that owns the HI/LO register pair.
// Runs mult/multu/div/divu over 33 cycles (32 RUN + 1 FIX) and holds the
// results in HI/LO for mfhi/mflo. While an operation is in flight, busy
// requests a pipeline stall.
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset
//   start  in   begin operation `op` on a/b (sampled only when idle)
//   op     in   00 multu, 01 mult, 10 divu, 11 div
//   a      in   rs operand (multiplicand / dividend); mthi/mtlo source
//   b      in   rt operand (multiplier / divisor)
//   mthi   in   load HI from a (idle, no start)
//   mtlo   in   load LO from a (idle, no start)
//   busy   out  operation in progress
//   done   out  one-cycle pulse after HI/LO are written by an operation
//   hi     out  HI register (product high / remainder)
//   lo     out  LO register (product low / quotient)
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e      state_q, state_d;
  logic [4:0]  count_q;
  logic        is_div_q, sa_q, sb_q, dbz_q;
  logic [31:0] opa_q, opb_q;
  // Multiply: {running high sum, multiplier shifting out}.
  // Divide: low half shifts dividend bits out and quotient bits in.
  logic [63:0] acc_q;
  logic [31:0] rem_q;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic        accept;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] rem_shift;
  logic        q_bit;
  logic [31:0] rem_diff;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix, raw_a;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (count_q == 5'd0) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs, all decoded from registers
  always_comb begin
    busy = (state_q != StIdle);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

  // Datapath combinational helpers
  always_comb begin
    accept = (state_q == StIdle) && start;
    a_mag  = (op[0] && a[31]) ? (32'd0 - a) : a;
    b_mag  = (op[0] && b[31]) ? (32'd0 - b) : b;

    mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);

    // Restoring step: the remainder always stays below the divisor, so the
    // difference fits in 32 bits whenever the trial subtraction succeeds.
    rem_shift = {rem_q, acc_q[31]};
    q_bit     = (rem_shift >= {1'b0, opb_q});
    rem_diff  = rem_shift[31:0] - opb_q;

    prod_fix = (sa_q ^ sb_q) ? (64'd0 - acc_q) : acc_q;
    quot_fix = (sa_q ^ sb_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rem_fix  = sa_q ? (32'd0 - rem_q) : rem_q;
    // Undo the magnitude conversion to recover the dividend as presented.
    raw_a    = sa_q ? (32'd0 - opa_q) : opa_q;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= 5'd0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dbz_q    <= 1'b0;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      acc_q    <= 64'd0;
      rem_q    <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == StFix);
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            count_q  <= 5'd31;
            is_div_q <= op[1];
            sa_q     <= op[0] & a[31];
            sb_q     <= op[0] & b[31];
            dbz_q    <= op[1] && (b == 32'd0);
            opa_q    <= a_mag;
            opb_q    <= b_mag;
            rem_q    <= 32'd0;
            acc_q    <= op[1] ? {32'd0, a_mag} : {32'd0, b_mag};
          end else begin
            if (mthi) hi_q <= a;
            if (mtlo) lo_q <= a;
          end
        end
        StRun: begin
          count_q <= count_q - 5'd1;
          if (is_div_q) begin
            rem_q        <= q_bit ? rem_diff : rem_shift[31:0];
            acc_q[31:0]  <= {acc_q[30:0], q_bit};
          end else begin
            acc_q <= {mul_sum, acc_q[31:1]};
          end
        end
        StFix: begin
          if (!is_div_q) begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end else if (dbz_q) begin
            hi_q <= raw_a;
            lo_q <= 32'hFFFF_FFFF;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        mthi, mtlo;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_assert = 0;
  int n_fail   = 0;

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one operation, optionally with mthi on the start cycle and a
  // competing start/move request while busy at loop step `interfere_at`.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                        input logic with_mthi, input int interfere_at);
    logic [31:0] h0, l0;
    int n;
    logic stable_ok, done_low_ok;
    h0 = hi;
    l0 = lo;
    start = 1'b1; op = o; a = av; b = bv; mthi = with_mthi;
    tick();
    start = 1'b0; mthi = 1'b0; a = $urandom; b = $urandom;
    chk({tag, "_done_after_start"}, {31'd0, done}, 32'd0);
    n = 0;
    stable_ok = 1'b1;
    done_low_ok = 1'b1;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (hi !== h0 || lo !== l0) stable_ok = 1'b0;
      if (done !== 1'b0) done_low_ok = 1'b0;
      if (n == interfere_at) begin
        start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3; mthi = 1'b1; mtlo = 1'b1;
      end
      tick();
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0; a = $urandom; b = $urandom;
    end
    chk({tag, "_busy_cycles"}, n, 32'd33);
    chk({tag, "_hilo_stable"}, {31'd0, stable_ok}, 32'd1);
    chk({tag, "_done_low_busy"}, {31'd0, done_low_ok}, 32'd1);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0; mthi = 1'b0; mtlo = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    // Each run_op returns in the done cycle, so the next start is back-to-back.
    run_op("multu_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
    run_op("mult_m3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, 0);
    run_op("mult_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 0);
    run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 0);
    run_op("divu_by0", 2'b10, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b0, 0);
    run_op("div_by0_neg", 2'b11, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b0, 0);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 10);
    tick();
    chk("done_one_cycle", {31'd0, done}, 32'd0);

    // Reset in the middle of a multiply
    start = 1'b1; op = 2'b01; a = 32'd7; b = 32'd9;
    tick();
    start = 1'b0;
    repeat (14) tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (20) tick();
    chk("abort_no_done", {31'd0, done}, 32'd0);
    chk("abort_lo_hold", lo, 32'd0);

    // Idle moves
    mthi = 1'b1; a = 32'h1234_5678;
    tick();
    mthi = 1'b0; mtlo = 1'b1; a = 32'hCAFE_BABE;
    tick();
    mtlo = 1'b0;
    chk("mthi", hi, 32'h1234_5678);
    chk("mtlo", lo, 32'hCAFE_BABE);
    mthi = 1'b1; mtlo = 1'b1; a = 32'h55AA_55AA;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    chk("mtboth_hi", hi, 32'h55AA_55AA);
    chk("mtboth_lo", lo, 32'h55AA_55AA);
    chk("mt_busy", {31'd0, busy}, 32'd0);
    chk("mt_done", {31'd0, done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
